mem_arbiter: RTL

Shares the single unified memory port between the pipeline's instruction-fetch (F stage) and data-access (M stage) requesters. Grants one transaction at a time, drives the shared memory bus with a held request/ready handshake, and returns read data with a one-cycle completion pulse to the granted requester. Produces the fetch and memory-stage stall signals consumed by the hazard logic, and aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters.
// Data has fixed priority; a per-transaction counter aborts unacknowledged requests.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_ok,
  input  logic            data_req,
  input  logic            data_we,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  input  logic [DW/8-1:0] data_wstrb,
  output logic [DW-1:0]   data_rdata,
  output logic            data_ok,
  output logic            bus_err,
  output logic            stallF,
  output logic            stallM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INST = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] count;
  logic instGo, dataGo, expired, done;
  logic [DW-1:0] readData;

  // a requester still holding req during its ok cycle must not be re-granted
  assign instGo = inst_req & ~inst_ok;
  assign dataGo = data_req & ~data_ok;
  assign stallF = instGo;
  assign stallM = dataGo;

  always_comb begin
    expired = (count == LAST) & ~mem_ready;
    done = mem_ready | expired;
    readData = (mem_ready & ~mem_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      bus_err <= 1'b0;
      if (state == IDLE) begin
        count <= '0;
        if (dataGo) begin
          state <= DATA;
          mem_req <= 1'b1;
          mem_we <= data_we;
          mem_addr <= data_addr;
          mem_wdata <= data_wdata;
          mem_wstrb <= data_we ? data_wstrb : '0;
        end else if (instGo) begin
          state <= INST;
          mem_req <= 1'b1;
          mem_we <= 1'b0;
          mem_addr <= inst_addr;
          mem_wstrb <= '0;
        end
      end else if (done) begin
        state <= IDLE;
        mem_req <= 1'b0;
        bus_err <= ~mem_ready;
        if (state == INST) begin
          inst_ok <= 1'b1;
          inst_rdata <= readData;
        end else begin
          data_ok <= 1'b1;
          data_rdata <= readData;
        end
      end else begin
        count <= count + 8'd1;
      end
    end
  end
endmodule
